// File: rtl/uart_simple_core.sv
// Minimal 8N1 UART: free-running baud tick, transmitter and tick-sampled receiver on one clock.
// Define UART_SIMPLE_LOOPBACK_EN to feed the receiver from the internal tx_line instead of rx_line.
module uart_simple_core #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx_line,
  output logic       busy,
  output logic       done,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Baud generator: one-clock tick every DIV clocks
  logic [CNT_W-1:0] baud_cnt;
  logic             baud_tick_c;

  assign baud_tick_c = (baud_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) baud_cnt <= '0;
    else      baud_cnt <= baud_tick_c ? '0 : baud_cnt + CNT_W'(1);
  end

  // Transmitter
  tx_state_t  tx_state, tx_state_d;
  logic [7:0] tx_data, tx_data_d;
  logic [2:0] tx_idx, tx_idx_d;
  logic       tx_line_d, busy_d, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_data  <= 8'h00;
      tx_idx   <= 3'd0;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_data  <= tx_data_d;
      tx_idx   <= tx_idx_d;
      tx_line  <= tx_line_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_data_d  = tx_data;
    tx_idx_d   = tx_idx;
    done_d     = 1'b0;
    case (tx_state)
      TX_IDLE: if (start) begin
        tx_data_d  = data_in;
        tx_idx_d   = 3'd0;
        tx_state_d = TX_SYNC;
      end
      TX_SYNC:  if (baud_tick_c) tx_state_d = TX_START;
      TX_START: if (baud_tick_c) begin
        tx_idx_d   = 3'd0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (baud_tick_c) begin
        if (tx_idx == 3'd7) tx_state_d = TX_STOP;
        else                tx_idx_d   = tx_idx + 3'd1;
      end
      TX_STOP: if (baud_tick_c) begin
        tx_state_d = TX_IDLE;
        done_d     = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Outputs are registered from the next state so the line changes on the tick edge
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_data_d[tx_idx_d];
      default:  tx_line_d = 1'b1;
    endcase
    busy_d = (tx_state_d != TX_IDLE);
  end

  // Receiver input selection and 2-flop synchronizer
  logic       rx_src;
  logic [1:0] rx_sync;
  logic       rx_s;

`ifdef UART_SIMPLE_LOOPBACK_EN
  logic unused_rx_line;
  assign unused_rx_line = rx_line;
  assign rx_src         = tx_line;
`else
  assign rx_src = rx_line;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx_src};
  end
  assign rx_s = rx_sync[1];

  // Receiver: armed once the line is seen high in IDLE, samples only on the tick
  rx_state_t  rx_state, rx_state_d;
  logic [7:0] rx_shift, rx_shift_d;
  logic [2:0] rx_idx, rx_idx_d;
  logic       rx_armed, rx_armed_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_shift <= 8'h00;
      rx_idx   <= 3'd0;
      rx_armed <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_shift <= rx_shift_d;
      rx_idx   <= rx_idx_d;
      rx_armed <= rx_armed_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_shift_d = rx_shift;
    rx_idx_d   = rx_idx;
    rx_armed_d = rx_armed;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_s) rx_armed_d = 1'b1;
        if (rx_armed && !rx_s) begin
          rx_armed_d = 1'b0;
          rx_state_d = RX_START;
        end
      end
      RX_START: if (baud_tick_c) begin
        rx_idx_d   = 3'd0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (baud_tick_c) begin
        rx_shift_d = {rx_s, rx_shift[7:1]};
        if (rx_idx == 3'd7) rx_state_d = RX_STOP;
        else                rx_idx_d   = rx_idx + 3'd1;
      end
      RX_STOP: if (baud_tick_c) begin
        if (rx_s) begin
          rx_data_d  = rx_shift;
          rx_valid_d = 1'b1;
        end
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_simple_core.sv
// Self-checking bench for uart_simple_core (default build, receiver on rx_line).
// Loopback is emulated by routing tx_line back to rx_line from the bench.
module tb_uart_simple_core;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       tx_line, busy, done;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic ext_line;
  bit   lb;

  assign rx_line = lb ? tx_line : ext_line;

  uart_simple_core #(.CLK_HZ(1600), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .tx_line(tx_line), .busy(busy), .done(done),
    .rx_line(rx_line), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference baud phase: counts 0..DIV-1 from reset release, tick when at DIV-1
  int mcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) mcnt <= 0;
    else      mcnt <= (mcnt == DIV - 1) ? 0 : mcnt + 1;
  end

  // Receive monitor and loopback latency check
  logic [7:0] got[$];
  int cyc = 0;
  int last_done = -1000;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (done) last_done = cyc;
      if (rx_valid) begin
        got.push_back(rx_data);
        if (lb) check("rx_valid_after_done", ((cyc - last_done) >= 0) && ((cyc - last_done) <= 3), 1);
      end
    end
  end

  task automatic expect_rx(input logic [7:0] d);
    logic [7:0] g;
    check("rx_pending", got.size() > 0, 1);
    if (got.size() > 0) begin
      g = got.pop_front();
      check("rx_byte", g, d);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = d[i];
    f[9] = stop_bit;
    return f;
  endfunction

  // Send one byte by a start pulse and check every clock of the transmitted frame
  task automatic tx_frame(input logic [7:0] d, input logic [9:0] f, input bit poke);
    int lat;
    int errs;
    @(negedge clk); data_in = d; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    lat = 1;
    while (tx_line === 1'b1 && lat <= DIV + 1) begin
      @(negedge clk);
      lat++;
    end
    check("start_bit_latency", ((lat - 1) >= 1) && ((lat - 1) <= DIV), 1);
    if (lat > DIV + 1) return;
    errs = 0;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (k > 0) @(negedge clk);
      if (poke && k == 3 * DIV) begin start = 1'b1; data_in = 8'h12; end
      if (poke && k == 3 * DIV + 1) start = 1'b0;
      if (tx_line !== f[k / DIV] || busy !== 1'b1 || done !== 1'b0) errs++;
    end
    check("frame_shape_errs", errs, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_release", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    expect_rx(d);
    if (poke) begin
      repeat (2 * DIV) @(negedge clk);
      check("busy_start_ignored", busy, 0);
    end
  endtask

  // Drive an external frame on rx_line aligned to the baud phase
  task automatic send_ext(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = frame_of(d, stop_bit);
    for (int n = 0; n <= DIV; n++) begin
      @(negedge clk);
      if (mcnt == DIV - 1) break;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      ext_line = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    ext_line = 1'b1;
  endtask

  task automatic wait_sig(input bit is_done, input int budget, input string name);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (is_done ? (done === 1'b1) : (busy === 1'b1)) found = 1'b1;
    end
    check(name, found, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    bit         poke;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [7:0] d;
    int lat;

    vt[0] = '{8'hB3, 10'b1101100110, 1'b0};
    vt[1] = '{8'h00, 10'b1000000000, 1'b0};
    vt[2] = '{8'hFF, 10'b1111111110, 1'b0};
    vt[3] = '{8'h55, 10'b1010101010, 1'b0};
    vt[4] = '{8'h3C, 10'b1001111000, 1'b0};
    vt[5] = '{8'h81, 10'b1100000010, 1'b1};

    rst = 1'b0; start = 1'b0; data_in = 8'h00; ext_line = 1'b1; lb = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_line", tx_line, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven loopback frames
    for (int i = 0; i < 6; i++) tx_frame(vt[i].data, vt[i].frame, vt[i].poke);

    // Randomized loopback frames against the frame rule
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 2 * DIV)) @(negedge clk);
      tx_frame(d, frame_of(d, 1'b1), 1'b0);
    end

    // Back-to-back with start held high
    @(negedge clk); data_in = 8'h00; start = 1'b1;
    wait_sig(1'b0, 2 * DIV, "b2b_busy0");
    data_in = 8'hFF;
    wait_sig(1'b1, 12 * DIV, "b2b_done0");
    @(negedge clk);
    check("b2b_reaccept1", busy, 1);
    data_in = 8'h55;
    wait_sig(1'b1, 12 * DIV, "b2b_done1");
    @(negedge clk);
    check("b2b_reaccept2", busy, 1);
    start = 1'b0;
    wait_sig(1'b1, 12 * DIV, "b2b_done2");
    repeat (4) @(negedge clk);
    expect_rx(8'h00);
    expect_rx(8'hFF);
    expect_rx(8'h55);
    check("b2b_rx_count", got.size(), 0);

    // Reset during data bit 3
    @(negedge clk); data_in = 8'hC7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (tx_line === 1'b1 && lat <= DIV + 1) begin
      @(negedge clk);
      lat++;
    end
    check("rst_test_frame_started", tx_line, 0);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_tx_line", tx_line, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rx_valid", rx_valid, 0);
    repeat (3) @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    rst = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("midrst_no_partial_rx", got.size(), 0);
    tx_frame(8'hA5, 10'b1101001010, 1'b0);

    // External frames: framing error then a good frame
    lb = 1'b0;
    repeat (DIV) @(negedge clk);
    send_ext(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    check("framing_err_no_valid", got.size(), 0);
    repeat (2 * DIV) @(negedge clk);
    send_ext(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    expect_rx(8'h3C);
    check("ext_rx_data_hold", rx_data, 8'h3C);

    // One-clock glitch, then a good frame
    repeat (DIV / 2 + 3) @(negedge clk);
    ext_line = 1'b0;
    @(negedge clk);
    ext_line = 1'b1;
    repeat (DIV + 3) @(negedge clk);
    check("glitch_no_valid", got.size(), 0);
    send_ext(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    expect_rx(8'h5A);
    check("ext_rx_extra", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
